// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with a registered one-cycle detect pulse,
// selectable overlapping mode and a saturating match counter.
module seq_det_prog #(
   parameter int unsigned    LEN     = 4,
   parameter int unsigned    CNT_W   = 8,
   parameter logic [LEN-1:0] RST_PAT = LEN'(4'b1100)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i,
   input  logic             i_vld,
   input  logic             cfg_load,
   input  logic [LEN-1:0]   cfg_pat,
   input  logic             cfg_ovl,
   input  logic             cnt_clr,
   output logic             q,
   output logic [CNT_W-1:0] match_cnt,
   output logic             ovl
);

   localparam int unsigned      FW      = $clog2(LEN + 1);
   localparam logic [FW-1:0]    LEN_F   = FW'(LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {StIdle, StFill, StArmed} state_e;

   state_e           state_q, state_d;
   logic [LEN-1:0]   pat_q, pat_d;
   logic [LEN-1:0]   hist_q, hist_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             ovl_q, ovl_d;
   logic             q_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             hit;
   logic [LEN-1:0]   hist_sh;
   logic [FW-1:0]    fill_inc;

   // A bit presented alongside cfg_load is discarded.
   assign accept   = i_vld & ~cfg_load;
   assign hist_sh  = {hist_q[LEN-2:0], i};
   assign fill_inc = (fill_q == LEN_F) ? fill_q : fill_q + FW'(1);
   assign hit      = accept && (fill_inc == LEN_F) && (hist_sh == pat_q);

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      ovl_d   = ovl_q;

      if (cfg_load) begin
         pat_d   = cfg_pat;
         ovl_d   = cfg_ovl;
         hist_d  = '0;
         fill_d  = '0;
         state_d = StIdle;
      end else if (accept) begin
         hist_d = hist_sh;
         fill_d = (hit && !ovl_q) ? '0 : fill_inc;
         unique case (state_q)
            StIdle:  state_d = (fill_inc == LEN_F) ? StArmed : StFill;
            StFill:  begin
               if (hit && !ovl_q)          state_d = StIdle;
               else if (fill_inc == LEN_F) state_d = StArmed;
               else                        state_d = StFill;
            end
            StArmed: state_d = (hit && !ovl_q) ? StIdle : StArmed;
            default: state_d = StIdle;
         endcase
      end
   end

   // Clear wins over a simultaneous hit.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pat_q   <= RST_PAT;
         hist_q  <= '0;
         fill_q  <= '0;
         ovl_q   <= 1'b0;
         q_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         ovl_q   <= ovl_d;
         q_q     <= hit;
         cnt_q   <= cnt_d;
      end
   end

   assign q         = q_q;
   assign match_cnt = cnt_q;
   assign ovl       = ovl_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed vector bench for seq_det_prog: a default-width instance and a 2-bit
// counter instance share all inputs.
module tb_seq_det_prog;

   logic       clk = 1'b0;
   logic       rst_n, i, i_vld, cfg_load, cfg_ovl, cnt_clr;
   logic [3:0] cfg_pat;
   logic       q, ovl, q2, ovl2;
   logic [7:0] match_cnt;
   logic [1:0] match_cnt2;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   seq_det_prog #(.LEN(4), .CNT_W(8), .RST_PAT(4'b1100)) dut (
      .clk(clk), .rst_n(rst_n), .i(i), .i_vld(i_vld), .cfg_load(cfg_load),
      .cfg_pat(cfg_pat), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
      .q(q), .match_cnt(match_cnt), .ovl(ovl)
   );

   seq_det_prog #(.LEN(4), .CNT_W(2), .RST_PAT(4'b1100)) dut_c2 (
      .clk(clk), .rst_n(rst_n), .i(i), .i_vld(i_vld), .cfg_load(cfg_load),
      .cfg_pat(cfg_pat), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
      .q(q2), .match_cnt(match_cnt2), .ovl(ovl2)
   );

   typedef struct {
      logic       rst_n;
      logic       i;
      logic       vld;
      logic       ld;
      logic [3:0] pat;
      logic       ovl;
      logic       clr;
      logic       eq;
      int         ec;
      logic       eo;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic int sat3(input int c);
      return (c > 3) ? 3 : c;
   endfunction

   task automatic add(input logic r, input logic b, input logic v, input logic ld,
                      input logic [3:0] p, input logic o, input logic clr,
                      input logic eq, input int ec, input logic eo, input string name);
      vec_t t;
      t.rst_n = r; t.i = b; t.vld = v; t.ld = ld; t.pat = p; t.ovl = o; t.clr = clr;
      t.eq = eq; t.ec = ec; t.eo = eo; t.name = name;
      vecs.push_back(t);
   endtask

   // Drive one vector, clock it in, then check both instances.
   task automatic apply(input vec_t t, input int idx);
      rst_n = t.rst_n; i = t.i; i_vld = t.vld; cfg_load = t.ld;
      cfg_pat = t.pat; cfg_ovl = t.ovl; cnt_clr = t.clr;
      @(posedge clk);
      #1;
      nvec++;
      if (q !== t.eq || match_cnt !== 8'(t.ec) || ovl !== t.eo ||
          q2 !== t.eq || match_cnt2 !== 2'(sat3(t.ec)) || ovl2 !== t.eo) begin
         nerr++;
         $display("FAIL %s[%0d]: q=%b cnt=%0d ovl=%b q2=%b cnt2=%0d ovl2=%b, required q=%b cnt=%0d ovl=%b cnt2=%0d",
                  t.name, idx, q, match_cnt, ovl, q2, match_cnt2, ovl2,
                  t.eq, t.ec, t.eo, sat3(t.ec));
      end
   endtask

   // Shorthand for an accepted bit with no control activity.
   task automatic bit_in(input logic b, input logic eq, input int ec, input logic eo,
                         input string name);
      add(1, b, 1, 0, 4'h0, 0, 0, eq, ec, eo, name);
   endtask

   initial begin
      rst_n = 0; i = 0; i_vld = 0; cfg_load = 0; cfg_pat = 0; cfg_ovl = 0; cnt_clr = 0;

      // Reset state
      add(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, "reset");
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 0, "reset");

      // Default 1100, non-overlapping
      bit_in(1, 0, 0, 0, "dflt"); bit_in(1, 0, 0, 0, "dflt");
      bit_in(0, 0, 0, 0, "dflt"); bit_in(0, 1, 1, 0, "dflt");
      bit_in(1, 0, 1, 0, "dflt"); bit_in(1, 0, 1, 0, "dflt");
      bit_in(0, 0, 1, 0, "dflt"); bit_in(0, 1, 2, 0, "dflt");
      add(1, 1, 0, 0, 4'h0, 0, 0, 0, 2, 0, "dflt_idle");

      // 1010 overlapping
      add(1, 0, 0, 1, 4'b1010, 1, 0, 0, 2, 1, "load_ovl");
      bit_in(1, 0, 2, 1, "ovl"); bit_in(0, 0, 2, 1, "ovl");
      bit_in(1, 0, 2, 1, "ovl"); bit_in(0, 1, 3, 1, "ovl");
      bit_in(1, 0, 3, 1, "ovl"); bit_in(0, 1, 4, 1, "ovl");

      // 1010 non-overlapping, count cleared on the load edge
      add(1, 0, 0, 1, 4'b1010, 0, 1, 0, 0, 0, "load_novl");
      bit_in(1, 0, 0, 0, "novl"); bit_in(0, 0, 0, 0, "novl");
      bit_in(1, 0, 0, 0, "novl"); bit_in(0, 1, 1, 0, "novl");
      bit_in(1, 0, 1, 0, "novl"); bit_in(0, 0, 1, 0, "novl");
      bit_in(1, 0, 1, 0, "novl"); bit_in(0, 1, 2, 0, "novl");

      // 1100 with a 5-cycle valid gap before the completing bit
      add(1, 0, 0, 1, 4'b1100, 0, 1, 0, 0, 0, "load_gap");
      bit_in(1, 0, 0, 0, "gap"); bit_in(1, 0, 0, 0, "gap"); bit_in(0, 0, 0, 0, "gap");
      for (int k = 0; k < 5; k++) add(1, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0, "gap_hold");
      bit_in(0, 1, 1, 0, "gap_done");
      add(1, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0, "gap_pulse_end");

      // Reset mid-stream discards partial history
      bit_in(1, 0, 1, 0, "midrst"); bit_in(1, 0, 1, 0, "midrst"); bit_in(0, 0, 1, 0, "midrst");
      add(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, "midrst_rst");
      bit_in(0, 0, 0, 0, "midrst"); bit_in(1, 0, 0, 0, "midrst");
      bit_in(1, 0, 0, 0, "midrst"); bit_in(0, 0, 0, 0, "midrst");
      bit_in(0, 1, 1, 0, "midrst_hit");

      // cfg_load with the completing bit of a pending 1100 match
      bit_in(1, 0, 1, 0, "ldhit"); bit_in(1, 0, 1, 0, "ldhit"); bit_in(0, 0, 1, 0, "ldhit");
      add(1, 0, 1, 1, 4'b0110, 1, 0, 0, 1, 1, "ldhit_load");
      bit_in(0, 0, 1, 1, "newpat"); bit_in(1, 0, 1, 1, "newpat");
      bit_in(1, 0, 1, 1, "newpat"); bit_in(0, 1, 2, 1, "newpat");
      bit_in(1, 0, 2, 1, "newpat_ovl"); bit_in(1, 0, 2, 1, "newpat_ovl");
      bit_in(0, 1, 3, 1, "newpat_ovl");

      // Clear without a hit
      add(1, 0, 0, 0, 4'h0, 0, 1, 0, 0, 1, "clr");

      foreach (vecs[k]) apply(vecs[k], k);

      // Saturation: pattern 1111 overlapping, hit on every bit from the fourth.
      begin
         vec_t t;
         int   exp_cnt = 0;
         t.rst_n = 1; t.i = 0; t.vld = 0; t.ld = 1; t.pat = 4'b1111; t.ovl = 1; t.clr = 1;
         t.eq = 0; t.ec = 0; t.eo = 1; t.name = "sat_load";
         apply(t, 0);
         for (int b = 1; b <= 10; b++) begin
            t.ld = 0; t.i = 1; t.vld = 1; t.pat = 4'h0;
            t.clr = (b == 10);
            t.eq = (b >= 4);
            if (t.clr) exp_cnt = 0;
            else if (b >= 4) exp_cnt++;
            t.ec = exp_cnt;
            t.name = "sat";
            apply(t, b);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
